// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default constants for the fetch PC unit.
// Imported by pc_ras and pc_unit.
package pc_pkg;

    typedef enum logic {
        PC_IDLE,
        PC_RUN
    } pc_state_e;

    localparam int          PC_ADDR_W    = 32;
    localparam int          PC_STEP      = 4;
    localparam int unsigned PC_RESET_VEC = 0;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with sticky over/underflow flag.
// A push when full overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W    = PC_ADDR_W,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [CNT_W-1:0]  cnt;

    assign ptr_inc = ptr + 1'b1;
    assign ptr_dec = ptr - 1'b1;
    assign top     = mem[ptr];
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(RAS_DEPTH));

    // Stack pointer, occupancy, entries and sticky flag; pop beats push.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            ptr <= '0;
            cnt <= '0;
        end else if (pop) begin
            if (empty) begin
                ovf <= 1'b1;
            end else begin
                ptr <= ptr_dec;
                cnt <= cnt - 1'b1;
            end
        end else if (push) begin
            ptr          <= ptr_inc;
            mem[ptr_inc] <= data;
            if (full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with IDLE/RUN control, redirects and RAS.
// Optional PC_ALIGN_CHECK_EN adds misalign_o and refuses unaligned redirects.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W,
    parameter int                STEP      = PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic              call_i,
    input  logic              ret_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic [ADDR_W-1:0] link_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              running_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              ras_ovf_o
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    pc_state_e         state;
    pc_state_e         state_n;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_n;
    logic [ADDR_W-1:0] dest;
    logic              redirect;
    logic              act;
    logic              ras_clr;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] ras_dest;

    assign act      = (state == PC_RUN) && start_i;
    assign ras_clr  = (state == PC_RUN) && !start_i;
    assign ras_pop  = act && ret_i;
    assign ras_push = act && !ret_i && jump_i && call_i;
    assign ras_dest = ras_empty_o ? RESET_VEC : ras_top;

    assign pc_o      = pc_q;
    assign running_o = (state == PC_RUN);

    pc_ras #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr  (ras_clr),
        .push (ras_push),
        .pop  (ras_pop),
        .data (link_i),
        .top  (ras_top),
        .empty(ras_empty_o),
        .full (ras_full_o),
        .ovf  (ras_ovf_o)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic mis_n;
`endif

    // Next state and next PC: stop, return, jump, stall, increment.
    always_comb begin
        state_n  = state;
        pc_n     = pc_q;
        dest     = '0;
        redirect = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        mis_n    = 1'b0;
`endif
        unique case (state)
            PC_IDLE: begin
                pc_n = RESET_VEC;
                if (start_i) begin
                    state_n = PC_RUN;
                end
            end
            PC_RUN: begin
                if (!start_i) begin
                    state_n = PC_IDLE;
                    pc_n    = RESET_VEC;
                end else if (ret_i) begin
                    redirect = 1'b1;
                    dest     = ras_dest;
                end else if (jump_i) begin
                    redirect = 1'b1;
                    dest     = target_i;
                end else if (!stall_i) begin
                    pc_n = pc_q + STEP_V;
                end
            end
            default: state_n = PC_IDLE;
        endcase
        if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
            if ((dest % STEP_V) != '0) begin
                mis_n = 1'b1;
            end else begin
                pc_n = dest;
            end
`else
            pc_n = dest;
`endif
        end
    end

    // State and PC registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= PC_IDLE;
            pc_q  <= RESET_VEC;
        end else begin
            state <= state_n;
            pc_q  <= pc_n;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // One-cycle pulse for a refused unaligned redirect.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= mis_n;
        end
    end
`endif

endmodule
